// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and execute load/store.
// Data has priority; fetch is guaranteed a slot after MAX_STARVE data grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int LOAD_LATENCY = 1,
    parameter int MAX_STARVE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_resp_data,
    input  logic                  d_req_valid,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic [DATA_W/8-1:0]   d_req_we,
    input  logic [DATA_W-1:0]     d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_W-1:0]     d_resp_data,
    input  logic                  flush,
    input  logic                  mem_ready,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [DATA_W-1:0]     mem_st_data,
    input  logic [DATA_W-1:0]     mem_ld_data
);

    localparam int BE_W = DATA_W / 8;
    localparam int NSTG = LOAD_LATENCY + 1;

    logic [3:0]          r_starve_cnt;
    logic                r_mem_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [BE_W-1:0]     r_mem_we;
    logic [DATA_W-1:0]   r_mem_st_data;
    logic [NSTG-1:0]     r_tag_valid;
    logic [NSTG-1:0]     r_tag_fetch;

    logic                w_arb_en;
    logic                w_if_want;
    logic                w_starved;
    logic                w_grant_f;
    logic                w_grant_d;
    logic                w_last_valid;
    logic [NSTG-1:0]     w_tag_valid_next;
    logic [NSTG-1:0]     w_tag_fetch_next;

    // A flushed fetch is treated as absent for arbitration.
    assign w_arb_en  = !rst && mem_ready;
    assign w_if_want = if_req_valid && !flush;
    assign w_starved = (r_starve_cnt == 4'(MAX_STARVE));
    assign w_grant_f = w_arb_en && w_if_want && (!d_req_valid || w_starved);
    assign w_grant_d = w_arb_en && d_req_valid && !(w_if_want && w_starved);

    assign if_req_ready = w_grant_f;
    assign d_req_ready  = w_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (mem_ready) begin
            if (w_grant_f || !if_req_valid) begin
                r_starve_cnt <= 4'd0;
            end else if (w_grant_d && !flush && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_we      <= '0;
            r_mem_st_data <= '0;
        end else if (w_grant_f) begin
            r_mem_en      <= 1'b1;
            r_mem_addr    <= if_req_addr;
            r_mem_we      <= '0;
            r_mem_st_data <= '0;
        end else if (w_grant_d) begin
            r_mem_en      <= 1'b1;
            r_mem_addr    <= d_req_addr;
            r_mem_we      <= d_req_we;
            r_mem_st_data <= d_req_wdata;
        end else begin
            r_mem_en      <= 1'b0;
        end
    end

    assign mem_en      = r_mem_en;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_st_data = r_mem_st_data;

    // Tag pipeline: stage 0 tracks the request on the port, the last stage
    // lines up with mem_ld_data. Only loads carry a valid tag.
    generate
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign w_tag_valid_next[gi] = w_grant_f || (w_grant_d && (d_req_we == '0));
                assign w_tag_fetch_next[gi] = w_grant_f;
            end else begin : g_shift
                assign w_tag_valid_next[gi] = r_tag_valid[gi-1] && !(flush && r_tag_fetch[gi-1]);
                assign w_tag_fetch_next[gi] = r_tag_fetch[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_valid <= '0;
            r_tag_fetch <= '0;
        end else begin
            r_tag_valid <= w_tag_valid_next;
            r_tag_fetch <= w_tag_fetch_next;
        end
    end

    // Gating with rst keeps responses from before a reset from surfacing.
    assign w_last_valid  = r_tag_valid[NSTG-1] && !rst;
    assign if_resp_valid = w_last_valid && r_tag_fetch[NSTG-1] && !flush;
    assign d_resp_valid  = w_last_valid && !r_tag_fetch[NSTG-1];
    assign if_resp_data  = if_resp_valid ? mem_ld_data : '0;
    assign d_resp_data   = d_resp_valid ? mem_ld_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a
// queue-based reference model of grants, issued requests and responses.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;
    localparam int LL     = 1;
    localparam int MAX_ST = 4;

    logic              clk;
    logic              rst;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              d_req_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic [BE_W-1:0]   d_req_we;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              flush;
    logic              mem_ready;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_we;
    logic [DATA_W-1:0] mem_st_data;
    logic [DATA_W-1:0] mem_ld_data;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_LATENCY(LL), .MAX_STARVE(MAX_ST)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .flush(flush), .mem_ready(mem_ready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_st_data(mem_st_data),
        .mem_ld_data(mem_ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int due;
        bit fetch;
    } resp_t;

    resp_t             pend[$];
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    int                starve_m = 0;
    bit                regs_known = 0;
    bit                last_gf = 0;
    bit                last_gd = 0;
    logic              exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic [BE_W-1:0]   exp_we;
    logic [DATA_W-1:0] exp_st;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: entered just after a negedge with inputs applied,
    // returns at the following negedge.
    task automatic cycle();
        bit    gf, gd, want_f, rf, rd;
        resp_t keep[$];
        resp_t r;
        #1;
        if (rst) pend.delete();
        if (flush) begin
            foreach (pend[i]) if (!pend[i].fetch) keep.push_back(pend[i]);
            pend = keep;
        end
        rf = 0;
        rd = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r  = pend.pop_front();
            rf = r.fetch;
            rd = !r.fetch;
        end
        gf = 0;
        gd = 0;
        want_f = if_req_valid && !flush;
        if (!rst && mem_ready) begin
            if (d_req_valid && want_f) begin
                if (starve_m == MAX_ST) gf = 1; else gd = 1;
            end else if (d_req_valid) gd = 1;
            else if (want_f) gf = 1;
        end
        chk("if_req_ready", 64'(if_req_ready), 64'(gf));
        chk("d_req_ready", 64'(d_req_ready), 64'(gd));
        chk("if_resp_valid", 64'(if_resp_valid), 64'(rf));
        chk("if_resp_data", if_resp_data, rf ? mem_ld_data : 64'd0);
        chk("d_resp_valid", 64'(d_resp_valid), 64'(rd));
        chk("d_resp_data", d_resp_data, rd ? mem_ld_data : 64'd0);
        if (regs_known) begin
            chk("mem_en", 64'(mem_en), 64'(exp_en));
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
            chk("mem_we", 64'(mem_we), 64'(exp_we));
            chk("mem_st_data", mem_st_data, exp_st);
        end
        last_gf = gf;
        last_gd = gd;
        if (rst) begin
            exp_en = 0; exp_addr = '0; exp_we = '0; exp_st = '0;
            starve_m = 0;
        end else begin
            if (gf) begin
                exp_en = 1; exp_addr = if_req_addr; exp_we = '0; exp_st = '0;
                pend.push_back('{due: cyc + 1 + LL, fetch: 1'b1});
            end else if (gd) begin
                exp_en = 1; exp_addr = d_req_addr; exp_we = d_req_we; exp_st = d_req_wdata;
                if (d_req_we == '0) pend.push_back('{due: cyc + 1 + LL, fetch: 1'b0});
            end else begin
                exp_en = 0;
            end
            if (mem_ready) begin
                if (gf || !if_req_valid) starve_m = 0;
                else if (gd && !flush && starve_m < MAX_ST) starve_m++;
            end
        end
        if (rst) regs_known = 1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] seq;
        rst = 1; flush = 0; mem_ready = 1;
        if_req_valid = 1; if_req_addr = 32'h80;
        d_req_valid = 1; d_req_addr = 32'h10; d_req_we = '0; d_req_wdata = '0;
        mem_ld_data = 64'h0;
        @(negedge clk);

        // Reset with both requesters valid.
        for (int i = 0; i < 3; i++) cycle();
        chk("reset_mem_en", 64'(mem_en), 64'd0);
        rst = 0;

        // Starvation pattern from a fresh counter.
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            seq = {seq[8:0], if_req_ready === 1'bx ? 1'b0 : last_gf};
        end
        chk("starve_seq", 64'(seq), 64'(10'b0000100001));

        // Single fetch.
        if_req_valid = 0; d_req_valid = 0;
        cycle(); cycle();
        if_req_valid = 1; if_req_addr = 32'h40; mem_ld_data = 64'h1122334455667788;
        cycle();
        if_req_valid = 0;
        chk("fetch_mem_en", 64'(mem_en), 64'd1);
        chk("fetch_mem_addr", 64'(mem_addr), 64'h40);
        cycle();
        #1;
        chk("fetch_resp_valid", 64'(if_resp_valid), 64'd1);
        chk("fetch_resp_data", if_resp_data, 64'h1122334455667788);
        cycle();

        // Store then load to the same address.
        d_req_valid = 1; d_req_addr = 32'h100; d_req_we = 8'hFF; d_req_wdata = 64'hDEADBEEF;
        cycle();
        chk("store_we", 64'(mem_we), 64'hFF);
        chk("store_data", mem_st_data, 64'hDEADBEEF);
        d_req_we = 8'h00;
        cycle();
        chk("load_we", 64'(mem_we), 64'h00);
        d_req_valid = 0;
        cycle();
        #1;
        chk("load_resp_valid", 64'(d_resp_valid), 64'd1);
        cycle();

        // Flush kills an in-flight fetch but not a data load.
        if_req_valid = 1; if_req_addr = 32'h44;
        cycle();
        if_req_valid = 0; flush = 1;
        d_req_valid = 1; d_req_addr = 32'h200; d_req_we = '0;
        cycle();
        flush = 0; d_req_valid = 0;
        #1;
        chk("flush_no_if_resp", 64'(if_resp_valid), 64'd0);
        cycle();
        #1;
        chk("flush_d_resp", 64'(d_resp_valid), 64'd1);
        cycle();

        // Backpressure.
        if_req_valid = 1; d_req_valid = 1;
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_no_ready", 64'(if_req_ready | d_req_ready), 64'd0);
            cycle();
        end
        chk("bp_mem_en_low", 64'(mem_en), 64'd0);
        mem_ready = 1;
        cycle();
        chk("bp_resume", 64'(mem_en), 64'd1);

        // Random traffic; requesters hold their request until accepted.
        for (int i = 0; i < 1500; i++) begin
            if (!if_req_valid || last_gf) begin
                if_req_valid = ($urandom % 3) != 0;
                if_req_addr  = $urandom;
            end
            if (!d_req_valid || last_gd) begin
                d_req_valid = ($urandom % 3) != 0;
                d_req_addr  = $urandom;
                d_req_we    = ($urandom % 2) ? '0 : BE_W'($urandom);
                d_req_wdata = {$urandom, $urandom};
            end
            flush       = ($urandom % 8) == 0;
            mem_ready   = ($urandom % 5) != 0;
            rst         = ($urandom % 200) == 0;
            mem_ld_data = {$urandom, $urandom};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester and the execute-phase load/store requester.
- Sits between the fetch/execute phases and the memory.
- Arbitrates with data priority and bounded fetch starvation.
- Registers the winning request onto the memory port and routes the fixed-latency read data back to the issuing requester.
- Drops stale fetch responses on pipeline flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; byte-enable width is DATA_W/8
LOAD_LATENCY, 1, cycles from memory request to valid mem_ld_data
MAX_STARVE, 4, max consecutive data grants while a fetch is pending (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_req_valid  in  1  fetch request
if_req_addr  in  ADDR_W  fetch address
if_req_ready  out  1  fetch request accepted this cycle
if_resp_valid  out  1  fetch read data valid
if_resp_data  out  DATA_W  fetch read data
d_req_valid  in  1  data request
d_req_addr  in  ADDR_W  data address
d_req_we  in  DATA_W/8  byte write enables; zero means load
d_req_wdata  in  DATA_W  store data
d_req_ready  out  1  data request accepted this cycle
d_resp_valid  out  1  load data valid
d_resp_data  out  DATA_W  load data
flush  in  1  kill all outstanding and same-cycle fetch traffic
mem_ready  in  1  memory can accept a request this cycle
mem_en  out  1  memory request valid (registered)
mem_addr  out  ADDR_W  registered request address
mem_we  out  DATA_W/8  registered byte enables
mem_st_data  out  DATA_W  registered store data
mem_ld_data  in  DATA_W  read data, LOAD_LATENCY cycles after mem_en

Behaviour:
- Clocking and reset: one clock domain, rising edge of clk. rst is synchronous and active-high.
- Reset values:
  - all outputs 0;
  - starve_cnt = 0;
  - response tag pipeline cleared.
- Reset mid-operation: in-flight responses are discarded and never presented.
- Grant logic is combinational in cycle t, evaluated only when rst=0 and mem_ready=1.
  - Only d_req_valid set: grant data.
  - Only if_req_valid set (and flush=0): grant fetch.
  - Both set: grant fetch if starve_cnt==MAX_STARVE, otherwise grant data.
  - flush=1: fetch is never granted that cycle.
  - Exactly one grant per cycle, or none.
- Ready outputs: if_req_ready = fetch grant; d_req_ready = data grant. Requesters hold valid, address and data until ready.
- starve_cnt update (4-bit):
  - fetch granted, or if_req_valid=0: clear to 0;
  - data granted while if_req_valid=1 and flush=0: increment, saturating at MAX_STARVE;
  - otherwise: hold.
- Issue: a grant in cycle t registers mem_en=1 and the winner's address, we and wdata, visible in cycle t+1.
  - For a fetch, mem_we=0 and mem_st_data=0.
  - No grant: mem_en=0 in t+1; address and data hold their previous values.
- Tag pipeline:
  - LOAD_LATENCY+1 stages, each {valid, is_fetch}, shifted every cycle.
  - Stage 0 is loaded together with mem_en.
  - A tag is valid only for loads: a fetch, or data with d_req_we==0. Stores produce no response.
- Response: when the final stage holds a valid tag (cycle t+1+LOAD_LATENCY):
  - is_fetch=1: assert if_resp_valid with if_resp_data = mem_ld_data;
  - is_fetch=0: assert d_resp_valid with d_resp_data = mem_ld_data.
  - Response outputs are combinational pass-through of mem_ld_data; the non-selected data output is 0.
  - At most one response per cycle. Order matches issue order.
- Flush in cycle c:
  - clears the valid bit of every fetch tag in the pipeline at the edge ending cycle c;
  - suppresses if_resp_valid in cycle c itself.
  - Data tags are unaffected. A data load issued before the flush still returns.
- mem_ready=0: no grant and ready outputs stay 0. starve_cnt holds. Outstanding responses still drain.
- Back-to-back: one accepted request per cycle with no bubbles.

Test Plan:
- Reset: hold rst=1 for 3 cycles with both requesters valid -> all outputs 0, no grant. First grant goes to data in the first cycle after rst=0.
- Single fetch, LOAD_LATENCY=1: addr=0x40 accepted in cycle 5 -> mem_en=1 and mem_addr=0x40 in cycle 6; if_resp_valid=1 with data=mem_ld_data (0x1122334455667788) in cycle 7.
- Store then load: store (addr 0x100, we=0xFF, wdata=0xDEADBEEF) then load (addr 0x100) on consecutive cycles -> mem_we=0xFF then 0x00. Exactly one d_resp_valid, two cycles after the load is accepted.
- Starvation, MAX_STARVE=4: both requesters continuously valid -> grant sequence D,D,D,D,F,D,D,D,D,F. starve_cnt returns to 0 after each F.
- Flush: fetch accepted in cycle 10, flush=1 in cycle 11 -> no if_resp_valid in cycle 12. A data load accepted in cycle 11 still returns d_resp_valid in cycle 13.
- Backpressure: mem_ready=0 for cycles 3-6 with both requesters valid -> no ready asserted and mem_en=0 in cycles 4-7. Grants resume in cycle 7.
